sd_spi_ctl: RTL and testbench
=============================

// Module: sd_spi_ctl
// PURPOSE
//  SPI master for the SD card. Its host side is driven by the CPU port controller through I/O ports FEh/FFh.
//  - Accepts commands on the rising edge of sd_signal.
//  - Runs card init clocking, chip-select control and full-duplex byte exchange.
//  - Reports busy/timeout status and the received byte back to the port controller.
// PARAMETERS
//  SLOW_DIV        32          SCLK half-period in clock cycles, slow mode (25 MHz -> ~390 kHz)
//  FAST_DIV        2           SCLK half-period in clock cycles, fast mode (25 MHz -> 6.25 MHz)
//  TIMEOUT_CYCLES  25000000    clock cycles of CS-low before sd_timeout sets (1 s at 25 MHz)
// PORTS
//  clock       in   1  system clock, all logic on posedge
//  resetn      in   1  reset, synchronous, active-low
//  sd_signal   in   1  command strobe; a 0->1 transition starts a command
//  sd_cmd      in   2  command ID, sampled on the sd_signal rising edge
//  sd_out      in   8  byte to transmit / option bits, sampled on the sd_signal rising edge
//  sd_din      out  8  last byte received from the card
//  sd_busy     out  1  1 = command in progress
//  sd_timeout  out  1  1 = CS held low longer than TIMEOUT_CYCLES (sticky)
//  spi_cs_n    out  1  card chip select, active low
//  spi_sclk    out  1  SPI clock, mode 0 (idle low)
//  spi_mosi    out  1  data to card
//  spi_miso    in   1  data from card
// BEHAVIOUR
//  Reset values: sd_din=FFh, sd_busy=0, sd_timeout=0, spi_cs_n=1, spi_sclk=0, spi_mosi=1.
//  Reset also forces slow mode and IDLE state, and sets the edge-detect register sig_q=1.
//  Reset mid-operation: abort at once, all outputs take reset values in the same cycle.
//  Edge detect: start = sd_signal & ~sig_q, with sig_q registered every cycle.
//   - A signal held high through reset does not trigger a command.
//   - A start while sd_busy=1 is ignored: no queueing, no state change.
//  Commands (start in cycle N):
//   0 INIT: spi_cs_n=1, spi_mosi=1, select slow mode. Emit 80 SCLK periods at SLOW_DIV.
//     Clears sd_timeout and the CS timer. sd_busy=1 from N+1 until the last falling edge.
//   1 XCHG: shift sd_out MSB first and receive 8 bits at the current divider.
//     CS is not touched; a transfer with CS high is still clocked.
//   2 CS_ON: from N+1, spi_cs_n=0 and mode = sd_out[0] ? fast : slow.
//     Clears sd_timeout and restarts the CS timer. sd_busy stays 0.
//   3 CS_OFF: from N+1, spi_cs_n=1 and the CS timer stops. sd_timeout keeps its value. sd_busy stays 0.
//  States: IDLE, INIT, XCHG.
//   - IDLE -> INIT on start with cmd 0; IDLE -> XCHG on start with cmd 1.
//   - INIT -> IDLE after 160 half-periods; XCHG -> IDLE after 16 half-periods.
//  Divider: a half-period counter runs 0..DIV-1 and toggles spi_sclk on wrap.
//   - The divider is latched at command start; a mode change never affects an active transfer.
//  XCHG timing (mode 0):
//   - Cycle N+1: shift register <- sd_out, spi_mosi = sd_out[7], sd_busy=1, spi_sclk=0.
//   - Each rising SCLK edge samples spi_miso into rx bit (7..0).
//   - Each falling edge shifts tx so the next bit is on spi_mosi.
//   - After the 8th falling edge: sd_din <- rx, sd_busy=0, spi_mosi=1, return to IDLE.
//     These take effect in the same cycle.
//   - sd_busy is high for exactly 16*DIV cycles. sd_din changes only at XCHG completion.
//  CS timer:
//   - Counts while spi_cs_n=0 and saturates at TIMEOUT_CYCLES.
//   - On reaching TIMEOUT_CYCLES, sd_timeout=1. It stays 1 until CS_ON, INIT or reset.
//   - Counter width is ceil(log2(TIMEOUT_CYCLES+1)).
//  Simultaneous events: a start in the completion cycle of XCHG/INIT is ignored (sd_busy still 1).
// TESTING
//  1. Reset with sd_signal held 1, then release reset -> no command runs.
//     Outputs: cs_n=1, sclk=0, mosi=1, busy=0, din=FFh.
//  2. CS_ON with sd_out=01h, then XCHG with sd_out=A5h while miso replays 3Ch.
//     -> mosi bits 1,0,1,0,0,1,0,1 at rising edges; busy high 32 cycles; sd_din=3Ch.
//  3. INIT after reset -> 80 SCLK periods of 64 cycles each, cs_n=1 and mosi=1 throughout.
//     busy high for 5120 cycles, then 0.
//  4. XCHG start issued again mid-transfer -> ignored: exactly 8 SCLK pulses, one sd_din update.
//  5. TIMEOUT_CYCLES=100, CS_ON, wait 100 cycles -> sd_timeout=1; CS_OFF keeps it 1; CS_ON clears it.
//  6. resetn=0 at the 4th SCLK rising edge of XCHG -> next cycle: sclk=0, cs_n=1, busy=0, din=FFh.

Source files
------------

// File: rtl/sd_spi_ctl.sv
// sd_spi_ctl -- SPI master (mode 0) for the SD card, driven by the CPU port
// controller through I/O ports FEh/FFh.
//
// A command starts on a 0->1 transition of sd_signal. sd_cmd and sd_out are
// sampled on that edge.
//   0 INIT   : CS high, MOSI high, slow mode, 80 SCLK periods
//   1 XCHG   : full-duplex byte exchange, MSB first
//   2 CS_ON  : CS low, speed from sd_out[0], restart the CS timer
//   3 CS_OFF : CS high, stop the CS timer
//
// Ports
//   clock       in   system clock, all logic on posedge
//   resetn      in   synchronous active-low reset
//   sd_signal   in   command strobe (rising edge starts a command)
//   sd_cmd      in   [1:0] command ID
//   sd_out      in   [7:0] byte to send / option bits
//   sd_din      out  [7:0] last byte received from the card
//   sd_busy     out  command in progress
//   sd_timeout  out  sticky: CS held low for TIMEOUT_CYCLES
//   spi_cs_n    out  card chip select, active low
//   spi_sclk    out  SPI clock, idle low
//   spi_mosi    out  data to card
//   spi_miso    in   data from card
module sd_spi_ctl #(
  parameter int SLOW_DIV       = 32,
  parameter int FAST_DIV       = 2,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       sd_signal,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DW      = $clog2(MAX_DIV + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DW-1:0] SLOW_V    = DW'(SLOW_DIV);
  localparam logic [DW-1:0] FAST_V    = DW'(FAST_DIV);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_XCHG = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic          sig_q;
  logic          start;
  logic          accept;
  logic          fast;
  logic [DW-1:0] div_sel;
  logic [DW-1:0] div_cnt;
  logic [7:0]    half_cnt;
  logic [7:0]    shift;
  logic [7:0]    rx;
  logic [TW-1:0] timer;

  logic          wrap;
  logic          last;
  logic          rise;

  // A strobe held high through reset is not an edge: sig_q resets to 1.
  assign start  = sd_signal & ~sig_q;
  // Starts are only honoured while idle; that also covers the completion
  // cycle, where the FSM is still in INIT/XCHG.
  assign accept = start & (state == ST_IDLE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept && sd_cmd == 2'd0) begin
          state_next = ST_INIT;
        end else if (accept && sd_cmd == 2'd1) begin
          state_next = ST_XCHG;
        end
      end
      ST_INIT, ST_XCHG: begin
        if (last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / control decode ----------------
  // wrap: half-period counter reaches the latched divider, SCLK toggles.
  // last: the toggle that completes the final half-period (160 for INIT,
  //       16 for XCHG); busy drops in the same cycle SCLK returns low.
  always_comb begin
    sd_busy = 1'b0;
    wrap    = 1'b0;
    last    = 1'b0;
    rise    = 1'b0;
    if (state != ST_IDLE) begin
      sd_busy = 1'b1;
      wrap    = (div_cnt == div_sel - DW'(1));
      last    = wrap && (half_cnt == ((state == ST_INIT) ? 8'd159 : 8'd15));
      rise    = wrap && !spi_sclk;
    end
  end

  // ---------------- SPI datapath ----------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sig_q    <= 1'b1;
      fast     <= 1'b0;
      div_sel  <= SLOW_V;
      div_cnt  <= '0;
      half_cnt <= '0;
      shift    <= '0;
      rx       <= '0;
      sd_din   <= 8'hFF;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b1;
    end else begin
      sig_q <= sd_signal;
      if (accept) begin
        unique case (sd_cmd)
          2'd0: begin
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b1;
            fast     <= 1'b0;
            div_sel  <= SLOW_V;
            div_cnt  <= '0;
            half_cnt <= '0;
            spi_sclk <= 1'b0;
          end
          2'd1: begin
            // Divider is captured here so a later CS_ON cannot disturb it.
            shift    <= sd_out;
            spi_mosi <= sd_out[7];
            div_sel  <= fast ? FAST_V : SLOW_V;
            div_cnt  <= '0;
            half_cnt <= '0;
            spi_sclk <= 1'b0;
          end
          2'd2: begin
            spi_cs_n <= 1'b0;
            fast     <= sd_out[0];
          end
          default: begin
            spi_cs_n <= 1'b1;
          end
        endcase
      end else if (wrap) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 8'd1;
        spi_sclk <= ~spi_sclk;
        if (state == ST_XCHG) begin
          if (rise) begin
            rx <= {rx[6:0], spi_miso};
          end else if (last) begin
            sd_din   <= rx;
            spi_mosi <= 1'b1;
          end else begin
            shift    <= {shift[6:0], 1'b0};
            spi_mosi <= shift[6];
          end
        end
      end else if (sd_busy) begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // ---------------- CS-low watchdog ----------------
  // Counts cycles with CS asserted and saturates; the flag is sticky until
  // INIT or CS_ON clears it. CS_OFF merely freezes the count.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      timer      <= '0;
      sd_timeout <= 1'b0;
    end else if (accept && (sd_cmd == 2'd0 || sd_cmd == 2'd2)) begin
      timer      <= '0;
      sd_timeout <= 1'b0;
    end else if (!spi_cs_n && timer != TIMEOUT_V) begin
      timer <= timer + TW'(1);
      if (timer + TW'(1) == TIMEOUT_V) begin
        sd_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_ctl.sv
// tb_sd_spi_ctl -- self-checking bench for sd_spi_ctl.
// A transaction-level model predicts every output each cycle from elapsed
// time since a command started; directed checks pin key literal results.
module tb_sd_spi_ctl;

  localparam int SLOW = 32;
  localparam int FAST = 2;
  localparam int TO   = 100;

  logic       clock = 1'b0;
  logic       resetn;
  logic       sd_signal;
  logic [1:0] sd_cmd;
  logic [7:0] sd_out;
  logic [7:0] sd_din;
  logic       sd_busy;
  logic       sd_timeout;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso = 1'b1;

  sd_spi_ctl #(
    .SLOW_DIV      (SLOW),
    .FAST_DIV      (FAST),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .sd_signal (sd_signal),
    .sd_cmd    (sd_cmd),
    .sd_out    (sd_out),
    .sd_din    (sd_din),
    .sd_busy   (sd_busy),
    .sd_timeout(sd_timeout),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cmp_prints = 0;

  // ---------------- model state ----------------
  bit         m_valid = 0;
  int         m_act   = 0;     // 0 none, 1 init, 2 exchange
  int         m_k     = 0;     // clock edges since command start
  int         m_div   = SLOW;
  int         m_len   = 16;    // half-periods in the running command
  logic [7:0] m_tx    = 8'h00;
  logic [7:0] m_rx    = 8'h00;
  logic [7:0] m_din   = 8'hFF;
  logic       m_cs    = 1'b1;
  logic       m_fast  = 1'b0;
  logic       m_to    = 1'b0;
  logic       m_sigq  = 1'b1;
  int         m_tcnt  = 0;
  logic [7:0] m_miso_byte = 8'hFF;   // byte the "card" replays

  initial begin : model_p
    bit st;
    int ph, f;
    logic [12:0] got, expv;
    forever begin
      @(posedge clock);
      if (!resetn) begin
        m_valid = 1; m_act = 0; m_k = 0; m_cs = 1'b1; m_fast = 1'b0;
        m_din = 8'hFF; m_to = 1'b0; m_tcnt = 0; m_sigq = 1'b1;
      end else begin
        st = sd_signal && !m_sigq;
        m_sigq = sd_signal;
        if (!m_cs) begin
          if (m_tcnt < TO) m_tcnt++;
          if (m_tcnt == TO) m_to = 1'b1;
        end
        if (m_act != 0) begin
          m_k++;
          if (m_act == 2 && (m_k % m_div) == 0 && ((m_k / m_div) % 2) == 1)
            m_rx = {m_rx[6:0], spi_miso};
          if (m_k == m_len * m_div) begin
            if (m_act == 2) m_din = m_rx;
            m_act = 0;
          end
        end else if (st) begin
          case (sd_cmd)
            2'd0: begin
              m_cs = 1'b1; m_fast = 1'b0; m_to = 1'b0; m_tcnt = 0;
              m_act = 1; m_div = SLOW; m_len = 160; m_k = 0;
            end
            2'd1: begin
              m_act = 2; m_div = m_fast ? FAST : SLOW; m_len = 16;
              m_tx = sd_out; m_k = 0;
            end
            2'd2: begin
              m_cs = 1'b0; m_fast = sd_out[0]; m_to = 1'b0; m_tcnt = 0;
            end
            default: m_cs = 1'b1;
          endcase
        end
      end

      @(negedge clock);
      // card side: present the next bit after each falling SCLK edge
      if (m_act == 2) begin
        f = (m_k / m_div) / 2;
        if (f > 7) f = 7;
        spi_miso = m_miso_byte[7 - f];
      end else begin
        spi_miso = m_miso_byte[7];
      end
      if (m_valid) begin
        ph = (m_act != 0) ? (m_k / m_div) : 0;
        expv = {m_din, (m_act != 0), m_to, m_cs,
                (m_act != 0) ? ph[0] : 1'b0,
                (m_act == 2) ? m_tx[7 - ph / 2] : 1'b1};
        got  = {sd_din, sd_busy, sd_timeout, spi_cs_n, spi_sclk, spi_mosi};
        tests++;
        if (got !== expv) begin
          fails++;
          if (cmp_prints < 10) begin
            cmp_prints++;
            $display("FAIL cycle_model t=%0t got din/busy/to/cs/sclk/mosi=%h expected %h",
                     $time, got, expv);
          end
        end
      end
    end
  end

  // ---------------- event monitor ----------------
  int         rises = 0;
  int         busy_cyc = 0;
  int         din_chg = 0;
  int         init_viol = 0;
  logic [7:0] mosi_bits = 8'h00;
  logic       prev_sclk = 1'b0;
  logic [7:0] prev_din = 8'hFF;

  always @(negedge clock) begin
    if (m_valid) begin
      if (spi_sclk && !prev_sclk) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], spi_mosi};
      end
      if (sd_busy) busy_cyc++;
      if (sd_din !== prev_din) din_chg++;
      if (sd_busy && (spi_cs_n !== 1'b1 || spi_mosi !== 1'b1)) init_viol++;
      prev_sclk = spi_sclk;
      prev_din  = sd_din;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cmd(input logic [1:0] c, input logic [7:0] d);
    @(negedge clock);
    sd_cmd = c; sd_out = d; sd_signal = 1'b1;
    @(negedge clock);
    sd_signal = 1'b0;
    $display("[TB] cmd %0d data %02h", c, d);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (sd_busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, sd_busy, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int r0, b0, d0, v0, cnt;
    logic ps;
    resetn = 1'b0; sd_signal = 1'b1; sd_cmd = 2'd0; sd_out = 8'h00;

    // 1: strobe held high through reset must not start anything
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("reset_pins cs/sclk/mosi/busy", {spi_cs_n, spi_sclk, spi_mosi, sd_busy}, 4'b1010);
    check("reset_din", sd_din, 8'hFF);
    check("reset_timeout", sd_timeout, 1'b0);
    sd_signal = 1'b0;

    // 2: fast exchange A5 against card byte 3C
    cmd(2'd2, 8'h01);
    m_miso_byte = 8'h3C;
    r0 = rises; b0 = busy_cyc;
    cmd(2'd1, 8'hA5);
    wait_idle(200, "xchg_a5_done");
    @(posedge clock); #1;
    check("xchg_a5_rises", rises - r0, 8);
    check("xchg_a5_busy_cycles", busy_cyc - b0, 32);
    check("xchg_a5_mosi_bits", mosi_bits, 8'hA5);
    check("xchg_a5_din", sd_din, 8'h3C);
    $display("[TB] xchg A5 -> din %02h", sd_din);

    // start landing on the completion cycle is dropped
    m_miso_byte = 8'hC3;
    cmd(2'd1, 8'h5A);
    repeat (31) @(negedge clock);
    sd_signal = 1'b1;
    @(negedge clock);
    sd_signal = 1'b0;
    repeat (3) @(negedge clock);
    check("completion_start_busy", sd_busy, 1'b0);
    check("completion_start_din", sd_din, 8'hC3);

    // 4: re-strobe mid-transfer is ignored
    m_miso_byte = 8'h96;
    r0 = rises; d0 = din_chg;
    cmd(2'd1, 8'h0F);
    repeat (5) @(negedge clock);
    sd_cmd = 2'd1; sd_out = 8'hFF; sd_signal = 1'b1;
    @(negedge clock);
    sd_signal = 1'b0;
    wait_idle(200, "restrobe_done");
    repeat (4) @(posedge clock); #1;
    check("restrobe_rises", rises - r0, 8);
    check("restrobe_din_updates", din_chg - d0, 1);
    check("restrobe_din", sd_din, 8'h96);

    // 5: CS watchdog
    cmd(2'd2, 8'h01);
    repeat (99) @(posedge clock); #1;
    check("timeout_before", sd_timeout, 1'b0);
    @(posedge clock); #1;
    check("timeout_at_limit", sd_timeout, 1'b1);
    cmd(2'd3, 8'h00);
    repeat (5) @(negedge clock);
    check("timeout_kept_cs_off", {spi_cs_n, sd_timeout}, 2'b11);
    cmd(2'd2, 8'h01);
    check("timeout_cleared_cs_on", {spi_cs_n, sd_timeout}, 2'b00);

    // 6: reset on the 4th rising SCLK edge of a slow exchange
    cmd(2'd2, 8'h00);
    m_miso_byte = 8'h55;
    cmd(2'd1, 8'hAA);
    cnt = 0; ps = spi_sclk;
    for (int i = 0; i < 1000 && cnt < 4; i++) begin
      @(posedge clock); #1;
      if (spi_sclk && !ps) cnt++;
      ps = spi_sclk;
    end
    check("abort_reached_4th_rise", cnt, 4);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("abort_sclk/cs/busy", {spi_sclk, spi_cs_n, sd_busy}, 3'b010);
    check("abort_din", sd_din, 8'hFF);
    @(negedge clock);
    resetn = 1'b1;
    $display("[TB] reset during exchange");

    // 3: INIT clocking
    repeat (2) @(negedge clock);
    r0 = rises; b0 = busy_cyc; v0 = init_viol;
    cmd(2'd0, 8'h00);
    wait_idle(6000, "init_done");
    @(posedge clock); #1;
    check("init_rises", rises - r0, 80);
    check("init_busy_cycles", busy_cyc - b0, 5120);
    check("init_cs_mosi_high", init_viol - v0, 0);
    check("init_end_pins cs/sclk/mosi", {spi_cs_n, spi_sclk, spi_mosi}, 3'b101);
    $display("[TB] init sequence complete");

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
